// File: rtl/axi2mem_rd_resp_buffer_pkg.sv
// Shared constants for the axi2mem read-response buffer.
package axi2mem_rd_resp_buffer_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int unsigned DefDataWidth   = 32;
    localparam int unsigned DefIdWidth     = 4;
    localparam int unsigned DefBufferDepth = 4;

endpackage

// File: rtl/axi2mem_rd_resp_buffer_if.sv
// Bundles the request, memory and R-channel signals of the read-response buffer.
interface axi2mem_rd_resp_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) ();

    logic                  req_valid;
    logic [31:0]           req_addr;
    logic [ID_WIDTH-1:0]   req_id;
    logic                  req_last;
    logic                  req_ready;

    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_last;
    logic [1:0]            r_resp;
    logic                  r_ready;

    // Environment side: address FSM, memory and R-channel consumer.
    modport master (
        output req_valid, req_addr, req_id, req_last, mem_gnt, mem_rvalid, mem_rdata, r_ready,
        input  req_ready, mem_req, mem_addr, r_valid, r_data, r_id, r_last, r_resp
    );

    modport slave (
        input  req_valid, req_addr, req_id, req_last, mem_gnt, mem_rvalid, mem_rdata, r_ready,
        output req_ready, mem_req, mem_addr, r_valid, r_data, r_id, r_last, r_resp
    );

endinterface

// File: rtl/axi2mem_rd_resp_buffer.sv
// Credit-based read issue plus response buffer: a memory read is only started when a slot
// is reserved for its data, since memory read data cannot be backpressured.
module axi2mem_rd_resp_buffer
    import axi2mem_rd_resp_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DefDataWidth,
    parameter int unsigned ID_WIDTH         = DefIdWidth,
    parameter int unsigned BUFFER_DEPTH     = DefBufferDepth,
    parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    axi2mem_rd_resp_buffer_if.slave  bus,
    output logic                     err_o
);

    localparam int unsigned CntWidth = LOG_BUFFER_DEPTH + 1;
    localparam logic [CntWidth-1:0]         CntFull = CntWidth'(BUFFER_DEPTH);
    localparam logic [LOG_BUFFER_DEPTH-1:0] PtrMax  = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic                last;
    } rd_tag_t;

    function automatic logic [LOG_BUFFER_DEPTH-1:0] ptr_inc(
        input logic [LOG_BUFFER_DEPTH-1:0] p
    );
        return (p == PtrMax) ? '0 : p + LOG_BUFFER_DEPTH'(1);
    endfunction

    rd_tag_t               tag_q  [BUFFER_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [BUFFER_DEPTH];

    logic [LOG_BUFFER_DEPTH-1:0] ptr_tag_in_q, ptr_tag_in_d;
    logic [LOG_BUFFER_DEPTH-1:0] ptr_data_in_q, ptr_data_in_d;
    logic [LOG_BUFFER_DEPTH-1:0] ptr_out_q, ptr_out_d;
    logic [CntWidth-1:0]         tag_cnt_q, tag_cnt_d;
    logic [CntWidth-1:0]         data_cnt_q, data_cnt_d;
    logic                        err_q, err_d;

    logic    credit, issue, pop, rvalid_ok;
    rd_tag_t out_tag;

    always_comb begin
        // Credit comes from registered state only, so a pop cannot free a slot same-cycle.
        credit    = (tag_cnt_q != CntFull);
        issue     = bus.req_valid & credit & bus.mem_gnt;
        pop       = (data_cnt_q != '0) & bus.r_ready;
        rvalid_ok = bus.mem_rvalid & (data_cnt_q != tag_cnt_q);

        ptr_tag_in_d  = issue     ? ptr_inc(ptr_tag_in_q)  : ptr_tag_in_q;
        ptr_data_in_d = rvalid_ok ? ptr_inc(ptr_data_in_q) : ptr_data_in_q;
        ptr_out_d     = pop       ? ptr_inc(ptr_out_q)     : ptr_out_q;

        tag_cnt_d  = tag_cnt_q + CntWidth'(issue) - CntWidth'(pop);
        data_cnt_d = data_cnt_q + CntWidth'(rvalid_ok) - CntWidth'(pop);
        err_d      = err_q | (bus.mem_rvalid & ~rvalid_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_tag_in_q  <= '0;
            ptr_data_in_q <= '0;
            ptr_out_q     <= '0;
            tag_cnt_q     <= '0;
            data_cnt_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            ptr_tag_in_q  <= ptr_tag_in_d;
            ptr_data_in_q <= ptr_data_in_d;
            ptr_out_q     <= ptr_out_d;
            tag_cnt_q     <= tag_cnt_d;
            data_cnt_q    <= data_cnt_d;
            err_q         <= err_d;
        end
    end

    // Storage is not reset; validity is tracked entirely by the counters.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            tag_q[ptr_tag_in_q] <= '{id: bus.req_id, last: bus.req_last};
        end
        if (rvalid_ok) begin
            data_q[ptr_data_in_q] <= bus.mem_rdata;
        end
    end

    assign out_tag = tag_q[ptr_out_q];

    assign bus.mem_req   = bus.req_valid & credit;
    assign bus.mem_addr  = bus.req_addr;
    assign bus.req_ready = credit & bus.mem_gnt;

    assign bus.r_valid = (data_cnt_q != '0);
    assign bus.r_data  = data_q[ptr_out_q];
    assign bus.r_id    = out_tag.id;
    assign bus.r_last  = out_tag.last;
    assign bus.r_resp  = RESP_OKAY;

    assign err_o = err_q;

endmodule

// File: tb/tb_axi2mem_rd_resp_buffer.sv
// Bench for axi2mem_rd_resp_buffer: directed scenarios plus random traffic, all checked
// against a queue-based model of reserved tags and arrived data.
module tb_axi2mem_rd_resp_buffer;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    logic err;

    axi2mem_rd_resp_buffer_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    axi2mem_rd_resp_buffer #(
        .DATA_WIDTH  (32),
        .ID_WIDTH    (4),
        .BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus),
        .err_o (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model: tags reserved in issue order, data in arrival order; heads pair up.
    logic [4:0]  tagq  [$];
    logic [31:0] dataq [$];
    logic        m_err = 1'b0;
    int          issued_cnt = 0;

    // Memory responder state.
    int          cyc = 0;
    int          pend [$];
    int          last_due = 0;
    bit          mem_auto = 1'b0;
    bit          mem_seq_mode = 1'b0;
    logic [31:0] mem_seq = 0;

    bit          collect = 1'b0;
    logic [36:0] got [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tagq.delete();
            dataq.delete();
            pend.delete();
            m_err = 1'b0;
        end else begin
            bit m_issue, m_pop, m_ok;
            int lat, due;
            cyc++;
            m_issue = bus.req_valid && bus.mem_gnt && (tagq.size() != DEPTH);
            m_pop   = (dataq.size() != 0) && bus.r_ready;
            m_ok    = bus.mem_rvalid && (dataq.size() != tagq.size());
            if (bus.mem_rvalid && !m_ok) m_err = 1'b1;
            if (m_pop) begin
                void'(tagq.pop_front());
                void'(dataq.pop_front());
            end
            if (m_issue) begin
                tagq.push_back({bus.req_id, bus.req_last});
                issued_cnt++;
                if (mem_auto) begin
                    lat = mem_seq_mode ? 1 : int'($urandom_range(1, 3));
                    due = cyc + lat - 1;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend.push_back(due);
                end
            end
            if (m_ok) dataq.push_back(bus.mem_rdata);
        end
    end

    always @(negedge clk) begin
        bit m_credit;
        m_credit = (tagq.size() != DEPTH);
        chk("req_ready", bus.req_ready, m_credit && bus.mem_gnt);
        chk("mem_req", bus.mem_req, bus.req_valid && m_credit);
        chk("mem_addr", bus.mem_addr, bus.req_addr);
        chk("r_valid", bus.r_valid, dataq.size() != 0);
        chk("r_resp", bus.r_resp, 2'b00);
        chk("err", err, m_err);
        if (dataq.size() != 0) begin
            chk("r_data", bus.r_data, dataq[0]);
            chk("r_id", bus.r_id, tagq[0][4:1]);
            chk("r_last", bus.r_last, tagq[0][0]);
            if (collect && bus.r_ready) got.push_back({bus.r_id, bus.r_last, bus.r_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        if (mem_auto && pend.size() != 0 && pend[0] <= cyc) begin
            void'(pend.pop_front());
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem_seq_mode ? mem_seq : $urandom;
            mem_seq++;
        end
    endtask

    task automatic drain();
        bus.req_valid = 1'b0;
        pend.delete();
        for (int i = 0; i < 64 && tagq.size() != 0; i++) begin
            bus.mem_rvalid = (tagq.size() > dataq.size());
            bus.mem_rdata  = $urandom;
            bus.r_ready    = 1'b1;
            step();
        end
        bus.r_ready = 1'b0;
        chk("drain_tag_cnt", dut.tag_cnt_q, 0);
        chk("drain_r_valid", bus.r_valid, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = '0;
        bus.req_id     = '0;
        bus.req_last   = 1'b0;
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.r_ready    = 1'b0;
        #3;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_mem_req", bus.mem_req, 1);
        chk("rst_r_valid", bus.r_valid, 0);
        chk("rst_err", err, 0);
        step();
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        step();

        // Single beat round trip.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h10;
        bus.req_id    = 4'd3;
        bus.req_last  = 1'b1;
        step();
        bus.req_valid  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        chk("single_not_yet_valid", bus.r_valid, 0);
        step();
        chk("single_r_valid", bus.r_valid, 1);
        chk("single_r_data", bus.r_data, 32'hDEADBEEF);
        chk("single_r_id", bus.r_id, 3);
        chk("single_r_last", bus.r_last, 1);
        chk("single_r_resp", bus.r_resp, 0);
        bus.r_ready = 1'b1;
        step();
        chk("single_popped", bus.r_valid, 0);
        bus.r_ready = 1'b0;

        // Credit exhaustion with the consumer stalled.
        bus.req_valid = 1'b1;
        bus.req_last  = 1'b0;
        bus.req_id    = 4'd7;
        repeat (4) step();
        chk("full_req_ready", bus.req_ready, 0);
        chk("full_mem_req", bus.mem_req, 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234;
        step();
        chk("full_still_blocked", bus.req_ready, 0);
        bus.r_ready = 1'b1;
        step();
        bus.r_ready = 1'b0;
        chk("after_pop_req_ready", bus.req_ready, 1);
        drain();

        // 10-beat burst across pointer wrap, consumer ready every other cycle.
        mem_auto     = 1'b1;
        mem_seq_mode = 1'b1;
        mem_seq      = 0;
        issued_cnt   = 0;
        got.delete();
        collect      = 1'b1;
        bus.req_id   = 4'd5;
        for (int c = 0; c < 200 && got.size() < 10; c++) begin
            bus.req_valid = (issued_cnt < 10);
            bus.req_addr  = issued_cnt;
            bus.req_last  = (issued_cnt == 9);
            bus.r_ready   = (c % 2 == 0);
            step();
        end
        collect     = 1'b0;
        mem_auto    = 1'b0;
        bus.r_ready = 1'b0;
        chk("burst_beats", got.size(), 10);
        for (int i = 0; i < got.size(); i++) begin
            chk("burst_data", got[i][31:0], i);
            chk("burst_id", got[i][36:33], 5);
            chk("burst_last", got[i][32], i == 9);
        end
        drain();

        // Issue, rvalid and pop all in one cycle net out.
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd9;
        repeat (2) step();
        bus.req_valid  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA5A5_0001;
        step();
        chk("pre_simul_tag_cnt", dut.tag_cnt_q, 2);
        chk("pre_simul_data_cnt", dut.data_cnt_q, 1);
        bus.req_valid  = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA5A5_0002;
        bus.r_ready    = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.r_ready   = 1'b0;
        chk("simul_tag_cnt", dut.tag_cnt_q, 2);
        chk("simul_data_cnt", dut.data_cnt_q, 1);
        chk("simul_r_data", bus.r_data, 32'hA5A5_0002);
        drain();

        // Stray rvalid with nothing outstanding.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD;
        step();
        chk("stray_err", err, 1);
        chk("stray_tag_cnt", dut.tag_cnt_q, 0);
        chk("stray_r_valid", bus.r_valid, 0);
        repeat (2) step();
        chk("stray_err_sticky", err, 1);

        // Asynchronous reset with three beats buffered.
        bus.req_valid = 1'b1;
        repeat (3) step();
        bus.req_valid = 1'b0;
        repeat (3) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
            step();
        end
        chk("prereset_r_valid", bus.r_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_r_valid", bus.r_valid, 0);
        chk("midreset_err", err, 0);
        chk("midreset_req_ready", bus.req_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        // Random traffic with variable memory latency.
        mem_auto     = 1'b1;
        mem_seq_mode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = ($urandom % 4) != 0;
            bus.mem_gnt   = ($urandom % 4) != 0;
            bus.r_ready   = ($urandom % 3) != 0;
            bus.req_addr  = $urandom;
            bus.req_id    = 4'($urandom);
            bus.req_last  = 1'($urandom);
            step();
        end
        mem_auto = 1'b0;
        drain();
        chk("final_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
